// File: rtl/vgafb_pkg.sv
// Shared constants for the VGA framebuffer halfword-to-word FIFO.
package vgafb_pkg;

  localparam int unsigned HALF_W          = 16;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEPTH_LOG2_DEF  = 4;
  localparam int unsigned BURST_WORDS_DEF = 8;

endpackage : vgafb_pkg

// File: rtl/vgafb_fifo_mem.sv
// Word storage for the framebuffer FIFO: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module vgafb_fifo_mem
  import vgafb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : vgafb_fifo_mem

// File: rtl/vgafb_fifo16to32.sv
// Packs 16-bit halfwords into 32-bit words (first halfword high) and queues them.
// Define VGAFB_FIFO_OVERFLOW_EN to build the sticky misuse detector on o_overflow.
module vgafb_fifo16to32
  import vgafb_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int unsigned BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_stb,
  input  logic [HALF_W-1:0] i_di,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_can_burst,
  output logic              o_do_valid,
  output logic [WORD_W-1:0] o_do,
  input  logic              i_next,
  output logic              o_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] r_produce;
  logic [DEPTH_LOG2-1:0] r_consume;
  logic [CNT_W-1:0]      r_count;
  logic                  r_pending;
  logic [HALF_W-1:0]     r_hold;
  logic                  r_ready;
  logic                  r_do_valid;
  logic                  r_can_burst;

  logic                  w_full;
  logic                  w_stb_ok;
  logic                  w_pop;
  logic                  w_commit;
  logic [WORD_W-1:0]     w_wdata;
  logic                  w_pending_nxt;
  logic [CNT_W-1:0]      w_count_nxt;

  // Decide whether a word is committed this cycle and what it contains.
  always_comb begin
    w_full        = (r_count == CNT_W'(DEPTH));
    w_stb_ok      = i_stb & r_ready;
    w_pop         = i_next & r_do_valid;
    w_commit      = 1'b0;
    w_wdata       = {r_hold, i_di};
    w_pending_nxt = r_pending;

    if (w_stb_ok && r_pending) begin
      w_commit      = 1'b1;
      w_pending_nxt = 1'b0;
    end else if (w_stb_ok) begin
      // A lone halfword with flush goes straight in, padded, if there is room.
      if (i_flush && !w_full) begin
        w_commit = 1'b1;
        w_wdata  = {i_di, HALF_W'(0)};
      end else begin
        w_pending_nxt = 1'b1;
      end
    end else if (i_flush && r_pending && !i_stb && !w_full) begin
      w_commit      = 1'b1;
      w_wdata       = {r_hold, HALF_W'(0)};
      w_pending_nxt = 1'b0;
    end

    unique case ({w_commit, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Status flags are registered from the next-state values so they track the count exactly.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_produce   <= '0;
      r_consume   <= '0;
      r_count     <= '0;
      r_pending   <= 1'b0;
      r_hold      <= '0;
      r_ready     <= 1'b1;
      r_do_valid  <= 1'b0;
      r_can_burst <= 1'b0;
    end else begin
      if (w_commit) r_produce <= r_produce + DEPTH_LOG2'(1);
      if (w_pop)    r_consume <= r_consume + DEPTH_LOG2'(1);
      if (w_stb_ok && !r_pending) r_hold <= i_di;
      r_count     <= w_count_nxt;
      r_pending   <= w_pending_nxt;
      r_ready     <= ~(w_pending_nxt & (w_count_nxt == CNT_W'(DEPTH)));
      r_do_valid  <= (w_count_nxt != '0);
      r_can_burst <= (w_count_nxt >= CNT_W'(BURST_WORDS));
    end
  end

  vgafb_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .i_clk   (i_sys_clk),
    .i_we    (w_commit),
    .i_waddr (r_produce),
    .i_wdata (w_wdata),
    .i_raddr (r_consume),
    .o_rdata (o_do)
  );

  assign o_ready     = r_ready;
  assign o_do_valid  = r_do_valid;
  assign o_can_burst = r_can_burst;

`ifdef VGAFB_FIFO_OVERFLOW_EN
  logic r_overflow;

  // Sticky until reset: strobe while not ready, or pop while empty.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_overflow <= 1'b0;
    end else if ((i_stb && !r_ready) || (i_next && !r_do_valid)) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

endmodule : vgafb_fifo16to32

// File: tb/tb_vgafb_fifo16to32.sv
// Scoreboard bench for vgafb_fifo16to32; follows VGAFB_FIFO_OVERFLOW_EN if defined.
module tb_vgafb_fifo16to32;
  import vgafb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb = 1'b0;
  logic [15:0] di = '0;
  logic        flush = 1'b0;
  logic        next = 1'b0;
  logic        o_ready;
  logic        o_can_burst;
  logic        o_do_valid;
  logic [31:0] o_do;
  logic        o_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb [$];
  logic        m_pending = 1'b0;
  logic [15:0] m_hold = '0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  vgafb_fifo16to32 dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_stb       (stb),
    .i_di        (di),
    .o_ready     (o_ready),
    .i_flush     (flush),
    .o_can_burst (o_can_burst),
    .o_do_valid  (o_do_valid),
    .o_do        (o_do),
    .i_next      (next),
    .o_overflow  (o_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return !(m_pending && sb.size() == 16);
  endfunction

  task automatic check_flags(input string tag);
    check_eq({tag, ".ready"},     32'(o_ready),     32'(m_ready()));
    check_eq({tag, ".do_valid"},  32'(o_do_valid),  32'(sb.size() != 0));
    check_eq({tag, ".can_burst"}, 32'(o_can_burst), 32'(sb.size() >= 8));
    check_eq({tag, ".overflow"},  32'(o_overflow),  32'(m_ovf));
    if (sb.size() != 0) check_eq({tag, ".do"}, o_do, sb[0]);
  endtask

  // One clock: drive inputs, update the model, score pops, then check outputs after the edge.
  task automatic cyc(input string tag, input logic s, input logic [15:0] d,
                     input logic f, input logic n);
    logic        full;
    logic        rdy;
    logic [31:0] exp;
    stb = s; di = d; flush = f; next = n;
    full = (sb.size() == 16);
    rdy  = m_ready();
`ifdef VGAFB_FIFO_OVERFLOW_EN
    if ((s && !rdy) || (n && sb.size() == 0)) m_ovf = 1'b1;
`endif
    if (n && sb.size() != 0) begin
      exp = sb.pop_front();
      check_eq({tag, ".pop"}, o_do, exp);
    end
    if (s && rdy) begin
      if (m_pending) begin
        sb.push_back({m_hold, d});
        m_pending = 1'b0;
      end else if (f && !full) begin
        sb.push_back({d, 16'h0000});
      end else begin
        m_pending = 1'b1;
        m_hold    = d;
      end
    end else if (f && m_pending && !s && !full) begin
      sb.push_back({m_hold, 16'h0000});
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    stb = 1'b0; flush = 1'b0; next = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    m_pending = 1'b0;
    m_ovf     = 1'b0;
    #2;
    check_flags("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_flags("rst_rel");
  endtask

  task automatic drain();
    while (sb.size() != 0) cyc("drain", 1'b0, 16'h0, 1'b0, 1'b1);
    check_eq("drained", 32'(o_do_valid), 32'(0));
  endtask

  initial begin
    #3;
    do_reset();

    // Basic pair packing
    cyc("p1a", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    cyc("p1b", 1'b1, 16'h5555, 1'b0, 1'b0);
    check_eq("aa55", o_do, 32'hAAAA5555);
    cyc("p1pop", 1'b0, 16'h0, 1'b0, 1'b1);

    // Fill to full, then a 33rd halfword leaves ready low
    for (int i = 0; i < 16; i++) begin
      cyc("fill_hi", 1'b1, 16'h0000, 1'b0, 1'b0);
      cyc("fill_lo", 1'b1, 16'(i), 1'b0, 1'b0);
      if (i == 7) check_eq("burst8", 32'(o_can_burst), 32'(1));
      if (i == 6) check_eq("burst7", 32'(o_can_burst), 32'(0));
    end
    cyc("h33", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check_eq("full_rdy", 32'(o_ready), 32'(0));
    cyc("stb_full", 1'b1, 16'h9999, 1'b0, 1'b0);

    // Pointer wrap with simultaneous commit and pop
    cyc("pop1", 1'b0, 16'h0, 1'b0, 1'b1);
    cyc("wrap_a", 1'b1, 16'hCAFE, 1'b0, 1'b0);
    cyc("wrap_b", 1'b1, 16'h1111, 1'b0, 1'b0);
    cyc("nx_stb", 1'b1, 16'h2222, 1'b0, 1'b1);
    cyc("both", 1'b1, 16'h2222, 1'b0, 1'b1);
    drain();

    // Flush variants
    cyc("f1", 1'b1, 16'h1234, 1'b0, 1'b0);
    cyc("f2", 1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("flush_pad", o_do, 32'h12340000);
    cyc("f3", 1'b0, 16'h0, 1'b1, 1'b0);
    cyc("f4", 1'b1, 16'h5678, 1'b1, 1'b0);
    cyc("f5", 1'b1, 16'h00AB, 1'b0, 1'b0);
    cyc("f6", 1'b1, 16'h00CD, 1'b1, 1'b0);
    drain();

    // Pop while empty
    cyc("ovf_next", 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (3) cyc("ovf_hold", 1'b0, 16'h0, 1'b0, 1'b0);
    check_eq("ovf_sticky", 32'(o_overflow), 32'(m_ovf));

    // Reset mid-pair with five words stored
    for (int i = 0; i < 5; i++) begin
      cyc("r_hi", 1'b1, 16'h00F0, 1'b0, 1'b0);
      cyc("r_lo", 1'b1, 16'(i), 1'b0, 1'b0);
    end
    cyc("r_half", 1'b1, 16'h7777, 1'b0, 1'b0);
    do_reset();
    cyc("pr_a", 1'b1, 16'hABCD, 1'b0, 1'b0);
    cyc("pr_b", 1'b1, 16'h0123, 1'b0, 1'b0);
    check_eq("post_rst", o_do, 32'hABCD0123);

    // Random traffic, including illegal strobes and pops
    repeat (400) begin
      cyc("rnd", 1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_vgafb_fifo16to32
